// File: rtl/alu_pipe.sv
// Two-stage integer execution unit: E1 captures the issued op, E2 computes and broadcasts.
// Latency 2 edges, 1 op/cycle, no back-pressure; rdy freezes everything, flush kills in-flight ops.
`ifndef ALU_PIPE_DEFS
`define ALU_PIPE_DEFS
`define XLEN           32
`define ALU_OP_WIDTH   4
`define ROB_SIZE_WIDTH 4
`define ALU_NOP  4'd0
`define ALU_ADD  4'd1
`define ALU_SUB  4'd2
`define ALU_AND  4'd3
`define ALU_OR   4'd4
`define ALU_XOR  4'd5
`define ALU_SHL  4'd6
`define ALU_SHR  4'd7
`define ALU_SHRA 4'd8
`define ALU_EQ   4'd9
`define ALU_NEQ  4'd10
`define ALU_LT   4'd11
`define ALU_LTU  4'd12
`define ALU_GE   4'd13
`define ALU_GEU  4'd14
`endif

module alu_pipe #(
  parameter int XLEN           = `XLEN,
  parameter int ALU_OP_WIDTH   = `ALU_OP_WIDTH,
  parameter int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      rs_ready,
  input  logic [ALU_OP_WIDTH-1:0]   rs_op,
  input  logic [XLEN-1:0]           rs_val1,
  input  logic [XLEN-1:0]           rs_val2,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_id,
  output logic                      alu_ready,
  output logic [XLEN-1:0]           alu_res,
  output logic [ROB_SIZE_WIDTH-1:0] alu_id
);

  localparam int SHW = $clog2(XLEN);

  logic                      e1_valid_q;
  logic [ALU_OP_WIDTH-1:0]   e1_op_q;
  logic [XLEN-1:0]           e1_v1_q;
  logic [XLEN-1:0]           e1_v2_q;
  logic [ROB_SIZE_WIDTH-1:0] e1_id_q;

  logic                      alu_ready_q;
  logic [XLEN-1:0]           alu_res_q;
  logic [ROB_SIZE_WIDTH-1:0] alu_id_q;

  logic [XLEN-1:0]           alu_res_d;
  logic [SHW-1:0]            shamt;

  assign shamt = e1_v2_q[SHW-1:0];

  // Compare results are zero-extended single bits; unknown opcodes yield zero.
  always_comb begin
    alu_res_d = '0;
    case (e1_op_q)
      `ALU_ADD:  alu_res_d = e1_v1_q + e1_v2_q;
      `ALU_SUB:  alu_res_d = e1_v1_q - e1_v2_q;
      `ALU_AND:  alu_res_d = e1_v1_q & e1_v2_q;
      `ALU_OR:   alu_res_d = e1_v1_q | e1_v2_q;
      `ALU_XOR:  alu_res_d = e1_v1_q ^ e1_v2_q;
      `ALU_SHL:  alu_res_d = e1_v1_q << shamt;
      `ALU_SHR:  alu_res_d = e1_v1_q >> shamt;
      `ALU_SHRA: alu_res_d = $unsigned($signed(e1_v1_q) >>> shamt);
      `ALU_EQ:   alu_res_d = {{(XLEN-1){1'b0}}, (e1_v1_q == e1_v2_q)};
      `ALU_NEQ:  alu_res_d = {{(XLEN-1){1'b0}}, (e1_v1_q != e1_v2_q)};
      `ALU_LT:   alu_res_d = {{(XLEN-1){1'b0}}, ($signed(e1_v1_q) < $signed(e1_v2_q))};
      `ALU_LTU:  alu_res_d = {{(XLEN-1){1'b0}}, (e1_v1_q < e1_v2_q)};
      `ALU_GE:   alu_res_d = {{(XLEN-1){1'b0}}, ($signed(e1_v1_q) >= $signed(e1_v2_q))};
      `ALU_GEU:  alu_res_d = {{(XLEN-1){1'b0}}, (e1_v1_q >= e1_v2_q)};
      default:   alu_res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        e1_valid_q  <= 1'b0;
        e1_op_q     <= '0;
        e1_v1_q     <= '0;
        e1_v2_q     <= '0;
        e1_id_q     <= '0;
        alu_ready_q <= 1'b0;
        alu_res_q   <= '0;
        alu_id_q    <= '0;
      end else if (flush) begin
        e1_valid_q  <= 1'b0;
        alu_ready_q <= 1'b0;
      end else begin
        e1_valid_q <= rs_ready;
        if (rs_ready) begin
          e1_op_q <= rs_op;
          e1_v1_q <= rs_val1;
          e1_v2_q <= rs_val2;
          e1_id_q <= rs_id;
        end
        // Result and tag hold their last values between pulses.
        alu_ready_q <= e1_valid_q;
        if (e1_valid_q) begin
          alu_res_q <= alu_res_d;
          alu_id_q  <= e1_id_q;
        end
      end
    end
  end

  assign alu_ready = alu_ready_q;
  assign alu_res   = alu_res_q;
  assign alu_id    = alu_id_q;

endmodule
